dec_nto2n_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with enable. It generalises the 3-to-8 decoder family to any input width. It adds a self-running scan mode that walks the active output across all positions at a programmable rate, for digit or row select in display and keypad blocks. It sits between control logic and multiplexed output drivers.

---
 rtl/dec_nto2n_seq_if.sv | 52 +++++
 rtl/dec_nto2n_seq.sv | 132 +++++++++++++
 tb/tb_dec_nto2n_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dec_nto2n_seq_if.sv
// dec_nto2n_seq_if: signal bundle between control logic and the N-to-2^N decoder.
//
// Ports grouped here:
//   en        enable; 0 forces out to all-zero
//   mode      0 = direct decode, 1 = scan
//   in        index to decode (direct) or load value (scan)
//   load      scan mode only: load in as current index
//   skip_mask (DEC_SEQ_SKIP_EN only) positions the scan steps over
//   out       registered one-hot output, or all-zero
//   idx       registered current index
//   wrap      1-cycle pulse when the scan index wraps
//
// Modports: master drives the controls, slave is the decoder.
// Macro DEC_SEQ_SKIP_EN adds skip_mask.

interface dec_nto2n_seq_if #(
    parameter int unsigned IN_W = 3
);
    localparam int unsigned OUT_W = 2 ** IN_W;

    logic              en;
    logic              mode;
    logic [IN_W-1:0]   in;
    logic              load;
    logic [OUT_W-1:0]  out;
    logic [IN_W-1:0]   idx;
    logic              wrap;
`ifdef DEC_SEQ_SKIP_EN
    logic [OUT_W-1:0]  skip_mask;

    modport master (
        output en, mode, in, load, skip_mask,
        input  out, idx, wrap
    );

    modport slave (
        input  en, mode, in, load, skip_mask,
        output out, idx, wrap
    );
`else
    modport master (
        output en, mode, in, load,
        input  out, idx, wrap
    );

    modport slave (
        input  en, mode, in, load,
        output out, idx, wrap
    );
`endif

endinterface

// File: rtl/dec_nto2n_seq.sv
// dec_nto2n_seq: registered N-to-2^N one-hot decoder with enable and a self-running scan mode
// that walks the active output across all positions every SCAN_DIV clocks (digit/row select).
//
// Parameters:
//   IN_W      index width; output width is 2**IN_W
//   SCAN_DIV  clock cycles per scan step, 1..65535
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dec_nto2n_seq_if.slave: en, mode, in, load (+skip_mask) in; out, idx, wrap out
//
// Operating state is decoded every edge from {en, mode}: idle, direct decode or scan.
// Optional macro DEC_SEQ_SKIP_EN: scan steps to the next position above idx whose
// skip_mask bit is clear; without it scan steps by exactly +1.

module dec_nto2n_seq #(
    parameter int unsigned IN_W     = 3,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    dec_nto2n_seq_if.slave  bus
);

    localparam int unsigned OUT_W = 2 ** IN_W;
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StDirect,
        StScan
    } state_e;

    state_e            state;
    logic [OUT_W-1:0]  out_q;
    logic [IN_W-1:0]   idx_q;
    logic              wrap_q;
    logic [DIV_W-1:0]  div_q;

    // Result of a scan step taken from the current index.
    logic [IN_W-1:0]   step_idx;
    logic              step_wrap;
    logic              step_blank;

    always_comb begin
        state = StIdle;
        if (bus.en) begin
            state = bus.mode ? StScan : StDirect;
        end
    end

`ifdef DEC_SEQ_SKIP_EN
    // Search upward (modulo OUT_W) for the first unmasked position other than idx itself.
    always_comb begin
        logic            found;
        logic [IN_W-1:0] cand;
        found    = 1'b0;
        cand     = '0;
        step_idx = idx_q;
        for (int unsigned k = 1; k < OUT_W; k++) begin
            cand = idx_q + IN_W'(k);
            if (!found && !bus.skip_mask[cand]) begin
                step_idx = cand;
                found    = 1'b1;
            end
        end
        // A landing position at or below the old index means the walk passed the top.
        step_wrap  = found && (step_idx <= idx_q);
        // Nothing else is selectable: idx holds, and is blanked if it is masked too.
        step_blank = !found && bus.skip_mask[idx_q];
    end
`else
    always_comb begin
        step_idx   = idx_q + IN_W'(1);
        step_wrap  = &idx_q;
        step_blank = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
            div_q  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    out_q  <= '0;
                    div_q  <= '0;
                    wrap_q <= 1'b0;
                end
                StDirect: begin
                    idx_q  <= bus.in;
                    out_q  <= ONE << bus.in;
                    div_q  <= '0;
                    wrap_q <= 1'b0;
                end
                StScan: begin
                    if (bus.load) begin
                        idx_q  <= bus.in;
                        out_q  <= ONE << bus.in;
                        div_q  <= '0;
                        wrap_q <= 1'b0;
                    end else if (div_q == DIV_LAST) begin
                        div_q  <= '0;
                        idx_q  <= step_idx;
                        out_q  <= step_blank ? '0 : (ONE << step_idx);
                        wrap_q <= step_wrap;
                    end else begin
                        div_q  <= div_q + DIV_W'(1);
                        out_q  <= ONE << idx_q;
                        wrap_q <= 1'b0;
                    end
                end
                default: begin
                    out_q  <= '0;
                    div_q  <= '0;
                    wrap_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out  = out_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_dec_nto2n_seq.sv
// tb_dec_nto2n_seq: directed bench for dec_nto2n_seq (IN_W=3, SCAN_DIV=4).
// A behavioural model tracks expected out/idx/wrap and is compared one time unit after
// every rising edge; literal expectations at key points pin the model itself.

module tb_dec_nto2n_seq;

    localparam int unsigned IN_W     = 3;
    localparam int unsigned OUT_W    = 8;
    localparam int unsigned SCAN_DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dec_nto2n_seq_if #(.IN_W(IN_W)) bus ();

    dec_nto2n_seq #(
        .IN_W     (IN_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: position number, edges spent at that position, one-hot image.
    int               m_idx  = 0;
    int               m_age  = 0;
    logic [OUT_W-1:0] m_out  = '0;
    logic             m_wrap = 1'b0;
    bit               cmp_on = 1'b0;

    function automatic logic [OUT_W-1:0] onehot(input int pos);
        logic [OUT_W-1:0] v;
        v = '0;
        v[pos] = 1'b1;
        return v;
    endfunction

    // Next scan position after cur, or -1 when no other position is selectable.
    function automatic int next_pos(input int cur);
`ifdef DEC_SEQ_SKIP_EN
        for (int k = 1; k < int'(OUT_W); k++) begin
            if (!bus.skip_mask[(cur + k) % OUT_W]) return (cur + k) % OUT_W;
        end
        return -1;
`else
        return (cur + 1) % OUT_W;
`endif
    endfunction

    function automatic bit cur_masked(input int cur);
`ifdef DEC_SEQ_SKIP_EN
        return bus.skip_mask[cur];
`else
        return cur < 0;
`endif
    endfunction

    always @(posedge clk) begin
        int n;
        if (!rst_n) begin
            m_idx = 0; m_age = 0; m_out = '0; m_wrap = 1'b0;
        end else if (!bus.en) begin
            m_out = '0; m_wrap = 1'b0; m_age = 0;
        end else if (!bus.mode || bus.load) begin
            m_idx = int'(bus.in); m_out = onehot(m_idx); m_wrap = 1'b0; m_age = 0;
        end else begin
            m_age++;
            if (m_age == int'(SCAN_DIV)) begin
                m_age = 0;
                n = next_pos(m_idx);
                if (n < 0) begin
                    m_wrap = 1'b0;
                    m_out  = cur_masked(m_idx) ? '0 : onehot(m_idx);
                end else begin
                    m_wrap = (n <= m_idx);
                    m_idx  = n;
                    m_out  = onehot(n);
                end
            end else begin
                m_out  = onehot(m_idx);
                m_wrap = 1'b0;
            end
        end
        #1;
        if (cmp_on) begin
            check("model_out",  32'(bus.out),  32'(m_out));
            check("model_idx",  32'(bus.idx),  32'(m_idx));
            check("model_wrap", 32'(bus.wrap), 32'(m_wrap));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] dir_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    int wraps;

    initial begin
        bus.en   = 1'b0;
        bus.mode = 1'b0;
        bus.in   = '0;
        bus.load = 1'b0;
`ifdef DEC_SEQ_SKIP_EN
        bus.skip_mask = '0;
`endif
        repeat (2) tick();
        check("reset_out",  32'(bus.out),  32'h0);
        check("reset_idx",  32'(bus.idx),  32'h0);
        check("reset_wrap", 32'(bus.wrap), 32'h0);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // Idle with a non-zero index presented.
        bus.in = 3'd5;
        repeat (3) begin
            tick();
            check("idle_out", 32'(bus.out), 32'h0);
            check("idle_idx", 32'(bus.idx), 32'h0);
        end

        // Direct decode sweep.
        bus.en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in = 3'(k);
            tick();
            check("direct_out", 32'(bus.out), 32'(dir_tbl[k]));
            check("direct_idx", 32'(bus.idx), 32'(k));
        end

        // Scan from idx=0 for 40 edges: steps on edges 4,8,..,40, wrap on edge 32.
        bus.in = 3'd0;
        tick();
        bus.mode = 1'b1;
        wraps = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            wraps += int'(bus.wrap);
            if (i == 3) check("scan_hold_idx", 32'(bus.idx), 32'd0);
            if (i == 4) check("scan_first_step", 32'(bus.idx), 32'd1);
            if (i == 32) check("scan_wrap_edge", 32'(bus.wrap), 32'd1);
        end
        check("scan_wrap_count", 32'(wraps), 32'd1);
        check("scan_end_idx", 32'(bus.idx), 32'd2);
        check("scan_end_out", 32'(bus.out), 32'h04);

        // Load at idx=2, divider=2.
        repeat (2) tick();
        check("pre_load_idx", 32'(bus.idx), 32'd2);
        bus.in = 3'd6; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check("load_idx",  32'(bus.idx),  32'd6);
        check("load_out",  32'(bus.out),  32'h40);
        check("load_wrap", 32'(bus.wrap), 32'd0);
        repeat (3) tick();
        check("load_hold_idx", 32'(bus.idx), 32'd6);
        tick();
        check("load_step_idx", 32'(bus.idx), 32'd7);
        check("load_step_out", 32'(bus.out), 32'h80);

        // Disable at idx=5, re-enable, pending step discarded.
        bus.in = 3'd5; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (2) tick();
        bus.en = 1'b0;
        tick();
        check("dis_out", 32'(bus.out), 32'h0);
        check("dis_idx", 32'(bus.idx), 32'd5);
        bus.en = 1'b1;
        tick();
        check("reen_out", 32'(bus.out), 32'h20);
        repeat (2) tick();
        check("reen_hold_idx", 32'(bus.idx), 32'd5);
        tick();
        check("reen_step_idx", 32'(bus.idx), 32'd6);

        // Asynchronous reset between edges.
        #1 rst_n = 1'b0;
        #1;
        check("async_out",  32'(bus.out),  32'h0);
        check("async_idx",  32'(bus.idx),  32'h0);
        check("async_wrap", 32'(bus.wrap), 32'h0);
        tick();
        rst_n  = 1'b1;
        bus.en = 1'b0;
        tick();
        check("post_rst_idx", 32'(bus.idx), 32'd0);

`ifdef DEC_SEQ_SKIP_EN
        // Skip mask: 0 -> 3 -> 6 -> 0 (wrap), then everything masked.
        bus.en = 1'b1; bus.mode = 1'b1;
        bus.skip_mask = 8'b1011_0110;
        bus.in = 3'd0; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (4) tick();
        check("skip_idx3", 32'(bus.idx), 32'd3);
        repeat (4) tick();
        check("skip_idx6", 32'(bus.idx), 32'd6);
        repeat (4) tick();
        check("skip_idx0",  32'(bus.idx),  32'd0);
        check("skip_wrap",  32'(bus.wrap), 32'd1);
        bus.skip_mask = 8'hFF;
        repeat (4) tick();
        check("skip_all_idx", 32'(bus.idx), 32'd0);
        check("skip_all_out", 32'(bus.out), 32'h0);
        bus.en = 1'b0;
        tick();
`endif

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
